// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the MEM stage: pipeline register structs, FSM state
// and load/store funct3 encodings.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regf_we;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic        br_en;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    wb_ctrl_t    wb_ctrl;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic        br_en;
    logic [31:0] mem_rdata_s;
    logic        misalign_s;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_stage_reg_t;

  // Halfwords must sit on even bytes, words on word boundaries.
  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] byte_off);
    case (funct3[1:0])
      2'b01:   return byte_off[0];
      2'b10:   return byte_off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the MEM stage: access mask, store-data shift and
// load-data extract with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_v,
  input  logic [31:0] load_raw,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] load_v
);

  logic [31:0] shifted;

  // Masks shift past bit 3 for unaligned accesses and are simply truncated.
  always_comb begin
    mask = 4'b0000;
    case (store_f3_t'({1'b0, funct3[1:0]}))
      sb:      mask = 4'b0001 << byte_off;
      sh:      mask = 4'b0011 << byte_off;
      default: mask = 4'b1111 << byte_off;
    endcase

    wdata   = store_v << {byte_off, 3'b000};
    shifted = load_raw >> {byte_off, 3'b000};

    load_v = shifted;
    case (load_f3_t'(funct3))
      lb:      load_v = {{24{shifted[7]}}, shifted[7:0]};
      lh:      load_v = {{16{shifted[15]}}, shifted[15:0]};
      lbu:     load_v = {24'h0, shifted[7:0]};
      lhu:     load_v = {16'h0, shifted[15:0]};
      default: load_v = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: EX/MEM register, single-request data-memory handshake, load alignment.
// Optional MEM_MISALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              move,
  input  ex_mem_stage_reg_t ex_mem_reg,
  output logic              mem_stall,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output mem_wb_stage_reg_t mem_wb_reg
);

  ex_mem_stage_reg_t ex_mem_q;
  mem_state_t        state;
  logic [31:0]       rdata_q;

  logic        is_load;
  logic        is_store;
  logic        misalign;
  logic        request;
  logic [3:0]  mask;
  logic [3:0]  rmask_t;
  logic [3:0]  wmask_t;
  logic [31:0] wdata;
  logic [31:0] load_v;
  logic [31:0] cur_rdata;

  assign is_load  = ex_mem_q.valid_s & ex_mem_q.mem_ctrl.mem_read;
  assign is_store = ex_mem_q.valid_s & ex_mem_q.mem_ctrl.mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = (is_load | is_store) &
                    is_misaligned(ex_mem_q.mem_ctrl.funct3, ex_mem_q.alu_out[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign request   = (state == IDLE) & (is_load | is_store) & ~misalign;
  assign cur_rdata = (state == WAIT) ? dmem_rdata : rdata_q;

  mem_align u_align (
    .funct3   (ex_mem_q.mem_ctrl.funct3),
    .byte_off (ex_mem_q.alu_out[1:0]),
    .store_v  (ex_mem_q.rs2_v),
    .load_raw (cur_rdata),
    .mask     (mask),
    .wdata    (wdata),
    .load_v   (load_v)
  );

  // Trace masks describe the request this instruction made, even after it completed.
  assign rmask_t    = (is_load & ~misalign) ? mask : 4'b0000;
  assign wmask_t    = (is_store & ~misalign) ? mask : 4'b0000;
  assign dmem_addr  = {ex_mem_q.alu_out[31:2], 2'b00};
  assign dmem_rmask = request ? rmask_t : 4'b0000;
  assign dmem_wmask = request ? wmask_t : 4'b0000;
  assign dmem_wdata = wdata;
  assign mem_stall  = request | ((state == WAIT) & ~dmem_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else if (move) begin
      ex_mem_q <= ex_mem_reg;
    end
  end

  // A response that coincides with move retires at once; otherwise park in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            state <= WAIT;
          end else if (misalign & ~move) begin
            state <= DONE;
          end
        end
        WAIT: begin
          if (dmem_resp) begin
            rdata_q <= dmem_rdata;
            state   <= move ? IDLE : DONE;
          end
        end
        DONE: begin
          if (move) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wb_reg             = '0;
    mem_wb_reg.valid_s     = move & ex_mem_q.valid_s;
    mem_wb_reg.inst        = ex_mem_q.inst;
    mem_wb_reg.pc          = ex_mem_q.pc;
    mem_wb_reg.pc_next     = ex_mem_q.pc_next;
    mem_wb_reg.order       = ex_mem_q.order;
    mem_wb_reg.wb_ctrl     = ex_mem_q.wb_ctrl;
    mem_wb_reg.rs1_s       = ex_mem_q.rs1_s;
    mem_wb_reg.rs2_s       = ex_mem_q.rs2_s;
    mem_wb_reg.rd_s        = ex_mem_q.rd_s;
    mem_wb_reg.rs1_v       = ex_mem_q.rs1_v;
    mem_wb_reg.rs2_v       = ex_mem_q.rs2_v;
    mem_wb_reg.alu_out     = ex_mem_q.alu_out;
    mem_wb_reg.u_imm       = ex_mem_q.u_imm;
    mem_wb_reg.br_en       = ex_mem_q.br_en;
    mem_wb_reg.mem_rdata_s = (is_load & ~misalign) ? load_v : 32'h0;
    mem_wb_reg.misalign_s  = misalign;
    mem_wb_reg.mem_addr    = (is_load | is_store) ? dmem_addr : 32'h0;
    mem_wb_reg.mem_rmask   = rmask_t;
    mem_wb_reg.mem_wmask   = wmask_t;
    mem_wb_reg.mem_rdata   = (is_load & ~misalign) ? cur_rdata : 32'h0;
    mem_wb_reg.mem_wdata   = (is_store & ~misalign) ? wdata : 32'h0;
  end

  move_while_stall: assert property (@(posedge clk) disable iff (rst) !(move && mem_stall));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset/misalign sequences
// and randomized load/store/ALU traffic checked against a byte-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              move;
  ex_mem_stage_reg_t ex_mem_reg;
  logic              mem_stall;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  mem_wb_stage_reg_t mem_wb_reg;

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          resp_dly;
    int          hold;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } vec_t;

  vec_t vecs[$];

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .move       (move),
    .ex_mem_reg (ex_mem_reg),
    .mem_stall  (mem_stall),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_wb_reg (mem_wb_reg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Byte-level reference: access size and offset decide everything.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, output logic [3:0] rm,
                                output logic [3:0] wm, output logic [31:0] wd,
                                output logic [31:0] lv);
    int unsigned      a;
    int unsigned      size;
    longint unsigned  m;
    longint unsigned  field;
    longint unsigned  bytes;
    a     = addr % 4;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bytes = (((64'd1 << size) - 1) << a) % 16;
    rm    = ld ? bytes[3:0] : 4'h0;
    wm    = st ? bytes[3:0] : 4'h0;
    wd    = 32'((64'(rs2) << (8 * a)) % (64'd1 << 32));
    m     = (64'd1 << (8 * size)) - 1;
    field = (64'(rdata) >> (8 * a)) & m;
    if (!f3[2] && size < 4 && field >= (64'd1 << (8 * size - 1))) begin
      field = field - (m + 1);
    end
    lv = ld ? field[31:0] : 32'h0;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    ex_mem_stage_reg_t ins;
    ins                  = '0;
    ins.valid_s          = 1'b1;
    ins.inst             = $urandom;
    ins.pc               = $urandom;
    ins.pc_next          = ins.pc + 32'd4;
    ins.order            = 64'($urandom);
    ins.mem_ctrl         = '{mem_read: v.ld, mem_write: v.st, funct3: v.f3};
    ins.rd_s             = 5'($urandom);
    ins.rs2_v            = v.rs2;
    ins.alu_out          = v.addr;
    ex_mem_reg = ins;
    move       = 1'b1;
    dmem_resp  = 1'b0;
    @(posedge clk); #1;
    ex_mem_reg = '0;
    if (!(v.ld || v.st)) begin
      @(negedge clk);
      check_output({v.name, "_stall"}, 32'(mem_stall), 32'h0);
      check_output({v.name, "_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'h0);
      check_output({v.name, "_alu"}, mem_wb_reg.alu_out, v.addr);
      check_output({v.name, "_valid"}, 32'(mem_wb_reg.valid_s), 32'h1);
      check_output({v.name, "_pc"}, mem_wb_reg.pc, ins.pc);
      @(posedge clk); #1;
      return;
    end
    move = 1'b0;
    @(negedge clk);
    check_output({v.name, "_req_stall"}, 32'(mem_stall), 32'h1);
    check_output({v.name, "_req_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
    check_output({v.name, "_req_rmask"}, 32'(dmem_rmask), 32'(v.rmask));
    check_output({v.name, "_req_wmask"}, 32'(dmem_wmask), 32'(v.wmask));
    if (v.st) check_output({v.name, "_req_wdata"}, dmem_wdata, v.wdata);
    for (int i = 0; i < v.resp_dly; i++) begin
      @(posedge clk); #1;
      dmem_rdata = $urandom;
      @(negedge clk);
      check_output({v.name, "_wait_stall"}, 32'(mem_stall), 32'h1);
      check_output({v.name, "_wait_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'h0);
    end
    @(posedge clk); #1;
    dmem_resp  = 1'b1;
    dmem_rdata = v.rdata;
    move       = (v.hold == 0);
    @(negedge clk);
    check_output({v.name, "_resp_stall"}, 32'(mem_stall), 32'h0);
    check_output({v.name, "_resp_valid"}, 32'(mem_wb_reg.valid_s), 32'(move));
    check_output({v.name, "_resp_data"}, mem_wb_reg.mem_rdata_s, v.ldata);
    check_output({v.name, "_trace_masks"}, 32'({mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask}),
                 32'({v.rmask, v.wmask}));
    check_output({v.name, "_misalign"}, 32'(mem_wb_reg.misalign_s), 32'h0);
    for (int i = 1; i <= v.hold; i++) begin
      @(posedge clk); #1;
      dmem_resp  = 1'($urandom);
      dmem_rdata = $urandom;
      move       = (i == v.hold);
      @(negedge clk);
      check_output({v.name, "_done_stall"}, 32'(mem_stall), 32'h0);
      check_output({v.name, "_done_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'h0);
      check_output({v.name, "_done_data"}, mem_wb_reg.mem_rdata_s, v.ldata);
      check_output({v.name, "_done_valid"}, 32'(mem_wb_reg.valid_s), 32'(move));
    end
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    move      = 1'b1;
  endtask

  initial begin
    vec_t v;
    ex_mem_stage_reg_t ins;
    rst        = 1'b1;
    move       = 1'b1;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    ex_mem_reg = '0;
    ex_mem_reg.valid_s = 1'b1;
    ex_mem_reg.mem_ctrl.mem_read = 1'b1;
    @(negedge clk);
    check_output("rst_valid", 32'(mem_wb_reg.valid_s), 32'h0);
    check_output("rst_stall", 32'(mem_stall), 32'h0);
    check_output("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
    @(posedge clk); #1;
    ex_mem_reg = '0;
    rst        = 1'b0;

    vecs.push_back('{"sw", 0, 1, 3'd2, 32'h1000, 32'hDEADBEEF, 32'h0, 1, 0, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{"lb", 1, 0, 3'd0, 32'h2003, 32'h0, 32'h80FFFFFF, 0, 0, 4'h8, 4'h0, 32'h0, 32'hFFFFFF80});
    vecs.push_back('{"lbu", 1, 0, 3'd4, 32'h2003, 32'h0, 32'h80FFFFFF, 0, 0, 4'h8, 4'h0, 32'h0, 32'h00000080});
    vecs.push_back('{"lh_hold", 1, 0, 3'd1, 32'h2002, 32'h0, 32'h80FF1234, 1, 2, 4'hC, 4'h0, 32'h0, 32'hFFFF80FF});
    vecs.push_back('{"lhu", 1, 0, 3'd5, 32'h2000, 32'h0, 32'h80FF9234, 2, 0, 4'h3, 4'h0, 32'h0, 32'h00009234});
    vecs.push_back('{"sb", 0, 1, 3'd0, 32'h1001, 32'h000000AB, 32'h0, 0, 1, 4'h0, 4'h2, 32'h0000AB00, 32'h0});
    vecs.push_back('{"sh", 0, 1, 3'd1, 32'h1002, 32'h00001234, 32'h0, 0, 0, 4'h0, 4'hC, 32'h12340000, 32'h0});
    vecs.push_back('{"lw", 1, 0, 3'd2, 32'h4000, 32'h0, 32'h12345678, 0, 0, 4'hF, 4'h0, 32'h0, 32'h12345678});
    vecs.push_back('{"add", 0, 0, 3'd0, 32'h00001234, 32'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0});
`ifndef MEM_MISALIGN_CHECK_EN
    vecs.push_back('{"lw_mis", 1, 0, 3'd2, 32'h3001, 32'h0, 32'hAABBCCDD, 0, 0, 4'hE, 4'h0, 32'h0, 32'h00AABBCC});
`endif
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Reset while waiting on memory; the late response must be dropped.
    ins = '0;
    ins.valid_s = 1'b1;
    ins.mem_ctrl = '{mem_read: 1'b1, mem_write: 1'b0, funct3: 3'd1};
    ins.alu_out = 32'h2002;
    ex_mem_reg = ins;
    move = 1'b1;
    @(posedge clk); #1;
    ex_mem_reg = '0;
    move = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rstw_wait_stall", 32'(mem_stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_output("rstw_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h5555AAAA;
    @(negedge clk);
    check_output("rstw_resp_stall", 32'(mem_stall), 32'h0);
    check_output("rstw_resp_masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    move      = 1'b1;
    @(negedge clk);
    check_output("rstw_valid", 32'(mem_wb_reg.valid_s), 32'h0);
    @(posedge clk); #1;

`ifdef MEM_MISALIGN_CHECK_EN
    ins = '0;
    ins.valid_s = 1'b1;
    ins.mem_ctrl = '{mem_read: 1'b1, mem_write: 1'b0, funct3: 3'd2};
    ins.alu_out = 32'h3001;
    ex_mem_reg = ins;
    move = 1'b1;
    @(posedge clk); #1;
    ex_mem_reg = '0;
    move = 1'b0;
    @(negedge clk);
    check_output("mis_stall", 32'(mem_stall), 32'h0);
    check_output("mis_rmask", 32'(dmem_rmask), 32'h0);
    check_output("mis_flag", 32'(mem_wb_reg.misalign_s), 32'h1);
    @(posedge clk); #1;
    move = 1'b1;
    @(negedge clk);
    check_output("mis_done_stall", 32'(mem_stall), 32'h0);
    check_output("mis_done_valid", 32'(mem_wb_reg.valid_s), 32'h1);
    check_output("mis_done_flag", 32'(mem_wb_reg.misalign_s), 32'h1);
    @(posedge clk); #1;
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind       = $urandom_range(0, 2);
      v.name     = "rnd";
      v.ld       = (kind == 1);
      v.st       = (kind == 2);
      v.f3       = (kind == 1) ? 3'(($urandom_range(0, 4) + 0)) : 3'($urandom_range(0, 2));
      if (kind == 1 && v.f3 == 3'd3) v.f3 = 3'd5;
      v.addr     = $urandom;
`ifdef MEM_MISALIGN_CHECK_EN
      if (v.f3[1:0] == 2'd1) v.addr[0] = 1'b0;
      if (v.f3[1:0] == 2'd2) v.addr[1:0] = 2'b00;
`endif
      v.rs2      = $urandom;
      v.rdata    = $urandom;
      v.resp_dly = $urandom_range(0, 2);
      v.hold     = $urandom_range(0, 2);
      model(v.ld, v.st, v.f3, v.addr, v.rs2, v.rdata, v.rmask, v.wmask, v.wdata, v.ldata);
      apply_stimulus(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
